mux16: RTL and testbench

- Parameterised 16:1 multiplexer of WIDTH-bit lanes.
- The cache instantiates it as the byte-select stage (WIDTH=8): the 4-bit byte offset picks one byte of a 128-bit cache block for the CPU read path.
- Primary output is purely combinational, so a hit returns data in the same cycle that Ready is asserted.
- A secondary registered copy of the selected lane, with synchronous reset and enable, is provided for pipelined consumers.

---
 rtl/mux16_pkg.sv | 5 +
 rtl/mux16.sv | 65 ++++++
 tb/tb_mux16.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux16_pkg.sv
// Shared constants for the 16-lane select stage.
package mux16_pkg;
   localparam int unsigned MUX16_LANES = 16;
   localparam int unsigned MUX16_SEL_W = 4;
endpackage

// File: rtl/mux16.sv
// 16:1 multiplexer of WIDTH-bit lanes with a combinational output and a
// registered copy (synchronous active-low clear, load enable).
module mux16
   import mux16_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [MUX16_SEL_W-1:0] sel_i,
   input  logic [WIDTH-1:0]       in0_i,
   input  logic [WIDTH-1:0]       in1_i,
   input  logic [WIDTH-1:0]       in2_i,
   input  logic [WIDTH-1:0]       in3_i,
   input  logic [WIDTH-1:0]       in4_i,
   input  logic [WIDTH-1:0]       in5_i,
   input  logic [WIDTH-1:0]       in6_i,
   input  logic [WIDTH-1:0]       in7_i,
   input  logic [WIDTH-1:0]       in8_i,
   input  logic [WIDTH-1:0]       in9_i,
   input  logic [WIDTH-1:0]       in10_i,
   input  logic [WIDTH-1:0]       in11_i,
   input  logic [WIDTH-1:0]       in12_i,
   input  logic [WIDTH-1:0]       in13_i,
   input  logic [WIDTH-1:0]       in14_i,
   input  logic [WIDTH-1:0]       in15_i,
   input  logic                   en_i,
   output logic [WIDTH-1:0]       out_o,
   output logic [WIDTH-1:0]       out_r_o
);

   // Default arm is only reachable when sel_i carries X/Z; it propagates X.
   always_comb begin
      out_o = {WIDTH{1'bx}};
      case (sel_i)
         4'h0: out_o = in0_i;
         4'h1: out_o = in1_i;
         4'h2: out_o = in2_i;
         4'h3: out_o = in3_i;
         4'h4: out_o = in4_i;
         4'h5: out_o = in5_i;
         4'h6: out_o = in6_i;
         4'h7: out_o = in7_i;
         4'h8: out_o = in8_i;
         4'h9: out_o = in9_i;
         4'hA: out_o = in10_i;
         4'hB: out_o = in11_i;
         4'hC: out_o = in12_i;
         4'hD: out_o = in13_i;
         4'hE: out_o = in14_i;
         4'hF: out_o = in15_i;
         default: out_o = {WIDTH{1'bx}};
      endcase
   end

   // Reset has priority over the load enable.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_r_o <= '0;
      end else if (en_i) begin
         out_r_o <= out_o;
      end
   end

endmodule

// File: tb/tb_mux16.sv
// Self-checking bench for mux16: directed byte-select scenarios at WIDTH=8
// plus randomized runs on WIDTH=1 and WIDTH=32 instances.
module tb_mux16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   int         compared = 0;
   int         mismatched = 0;

   logic [3:0]  sel8, sel1, sel32;
   logic [7:0]  l8  [16];
   logic        l1  [16];
   logic [31:0] l32 [16];
   logic [7:0]  out8, out_r8;
   logic        out1, out_r1;
   logic [31:0] out32, out_r32;

   logic [7:0]  exp_q8[$];
   logic [0:0]  exp_q1[$];
   logic [31:0] exp_q32[$];

   always #5 clk = ~clk;

   mux16 #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .sel_i(sel8),
      .in0_i(l8[0]), .in1_i(l8[1]), .in2_i(l8[2]), .in3_i(l8[3]),
      .in4_i(l8[4]), .in5_i(l8[5]), .in6_i(l8[6]), .in7_i(l8[7]),
      .in8_i(l8[8]), .in9_i(l8[9]), .in10_i(l8[10]), .in11_i(l8[11]),
      .in12_i(l8[12]), .in13_i(l8[13]), .in14_i(l8[14]), .in15_i(l8[15]),
      .en_i(en), .out_o(out8), .out_r_o(out_r8)
   );

   mux16 #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .sel_i(sel1),
      .in0_i(l1[0]), .in1_i(l1[1]), .in2_i(l1[2]), .in3_i(l1[3]),
      .in4_i(l1[4]), .in5_i(l1[5]), .in6_i(l1[6]), .in7_i(l1[7]),
      .in8_i(l1[8]), .in9_i(l1[9]), .in10_i(l1[10]), .in11_i(l1[11]),
      .in12_i(l1[12]), .in13_i(l1[13]), .in14_i(l1[14]), .in15_i(l1[15]),
      .en_i(en), .out_o(out1), .out_r_o(out_r1)
   );

   mux16 #(.WIDTH(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .sel_i(sel32),
      .in0_i(l32[0]), .in1_i(l32[1]), .in2_i(l32[2]), .in3_i(l32[3]),
      .in4_i(l32[4]), .in5_i(l32[5]), .in6_i(l32[6]), .in7_i(l32[7]),
      .in8_i(l32[8]), .in9_i(l32[9]), .in10_i(l32[10]), .in11_i(l32[11]),
      .in12_i(l32[12]), .in13_i(l32[13]), .in14_i(l32[14]), .in15_i(l32[15]),
      .en_i(en), .out_o(out32), .out_r_o(out_r32)
   );

   task automatic load_ramp();
      for (int n = 0; n < 16; n++) begin
         l8[n]  = 8'h10 + 8'(n);
         l1[n]  = 1'b0;
         l32[n] = 32'h0;
      end
      sel1  = 4'h0;
      sel32 = 4'h0;
   endtask

   task automatic test_reset();
      logic [7:0] got;
      @(negedge clk);
      load_ramp();
      sel8  = 4'hC;
      en    = 1'b1;
      rst_n = 1'b0;
      #1;
      compared++;
      if (out8 !== 8'h1C) begin
         mismatched++;
         $display("FAIL reset_comb_before_edge: got %h want 1c", out8);
      end
      exp_q8.push_back(8'h00);
      @(posedge clk);
      #1;
      got = exp_q8.pop_front();
      compared++;
      if (out_r8 !== got) begin
         mismatched++;
         $display("FAIL reset_out_r: got %h want %h", out_r8, got);
      end
      compared++;
      if (out8 !== 8'h1C) begin
         mismatched++;
         $display("FAIL reset_comb_during: got %h want 1c", out8);
      end
   endtask

   task automatic test_sweep();
      @(negedge clk);
      for (int s = 0; s < 16; s++) begin
         sel8 = 4'(s);
         #1;
         compared++;
         if (out8 !== 8'h10 + 8'(s)) begin
            mismatched++;
            $display("FAIL sweep_sel%0d: got %h want %h", s, out8, 8'h10 + 8'(s));
         end
      end
   endtask

   task automatic test_isolation();
      @(negedge clk);
      sel8 = 4'h7;
      l8[3] = 8'h00;
      #1;
      compared++;
      if (out8 !== 8'h17) begin
         mismatched++;
         $display("FAIL isolate_in3_00: got %h want 17", out8);
      end
      l8[3] = 8'hFF;
      #1;
      compared++;
      if (out8 !== 8'h17) begin
         mismatched++;
         $display("FAIL isolate_in3_ff: got %h want 17", out8);
      end
      l8[7] = 8'hA5;
      #1;
      compared++;
      if (out8 !== 8'hA5) begin
         mismatched++;
         $display("FAIL selected_lane_update: got %h want a5", out8);
      end
      l8[3] = 8'h13;
      l8[7] = 8'h17;
   endtask

   task automatic test_enable_hold();
      logic [7:0] got;
      @(negedge clk);
      rst_n = 1'b1;
      en    = 1'b1;
      sel8  = 4'hF;
      exp_q8.push_back(8'h1F);
      @(posedge clk);
      #1;
      got = exp_q8.pop_front();
      compared++;
      if (out_r8 !== got) begin
         mismatched++;
         $display("FAIL enable_load: got %h want %h", out_r8, got);
      end
      @(negedge clk);
      en   = 1'b0;
      sel8 = 4'h2;
      exp_q8.push_back(8'h1F);
      @(posedge clk);
      #1;
      got = exp_q8.pop_front();
      compared++;
      if (out_r8 !== got) begin
         mismatched++;
         $display("FAIL enable_hold: got %h want %h", out_r8, got);
      end
      compared++;
      if (out8 !== 8'h12) begin
         mismatched++;
         $display("FAIL hold_comb: got %h want 12", out8);
      end
   endtask

   task automatic test_reset_release();
      logic [7:0] got;
      @(negedge clk);
      rst_n = 1'b0;
      en    = 1'b1;
      sel8  = 4'h5;
      exp_q8.push_back(8'h00);
      @(posedge clk);
      #1;
      got = exp_q8.pop_front();
      compared++;
      if (out_r8 !== got) begin
         mismatched++;
         $display("FAIL release_in_reset: got %h want %h", out_r8, got);
      end
      @(negedge clk);
      rst_n = 1'b1;
      sel8  = 4'h9;
      l8[9] = 8'h6E;
      exp_q8.push_back(8'h6E);
      @(posedge clk);
      #1;
      got = exp_q8.pop_front();
      compared++;
      if (out_r8 !== got) begin
         mismatched++;
         $display("FAIL release_first_load: got %h want %h", out_r8, got);
      end
      l8[9] = 8'h19;
   endtask

   task automatic test_cache_block();
      logic [127:0] blk;
      @(negedge clk);
      blk = 128'h0F0E0D0C0B0A09080706050403020100;
      for (int n = 0; n < 16; n++) l8[n] = blk[8*n +: 8];
      sel8 = 4'hB;
      #1;
      compared++;
      if (out8 !== 8'h0B) begin
         mismatched++;
         $display("FAIL cache_byte_b: got %h want 0b", out8);
      end
      sel8 = 4'h0;
      #1;
      compared++;
      if (out8 !== 8'h00) begin
         mismatched++;
         $display("FAIL cache_byte_0: got %h want 00", out8);
      end
   endtask

   task automatic test_random();
      logic [0:0]  m1, r1, g1;
      logic [31:0] m32, r32, g32;
      r1  = 1'b0;
      r32 = 32'h0;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         rst_n = (c == 0) ? 1'b0 : ($urandom_range(0, 15) != 0);
         en    = 1'($urandom_range(0, 1));
         sel1  = 4'($urandom_range(0, 15));
         sel32 = 4'($urandom_range(0, 15));
         for (int n = 0; n < 16; n++) begin
            l1[n]  = 1'($urandom_range(0, 1));
            l32[n] = $urandom;
         end
         #1;
         m1  = l1[sel1];
         m32 = l32[sel32];
         compared++;
         if (out1 !== m1) begin
            mismatched++;
            $display("FAIL rand_w1_comb c%0d: got %b want %b", c, out1, m1);
         end
         compared++;
         if (out32 !== m32) begin
            mismatched++;
            $display("FAIL rand_w32_comb c%0d: got %h want %h", c, out32, m32);
         end
         if (!rst_n) begin
            r1  = 1'b0;
            r32 = 32'h0;
         end else if (en) begin
            r1  = m1;
            r32 = m32;
         end
         exp_q1.push_back(r1);
         exp_q32.push_back(r32);
         @(posedge clk);
         #1;
         g1  = exp_q1.pop_front();
         g32 = exp_q32.pop_front();
         compared++;
         if (out_r1 !== g1) begin
            mismatched++;
            $display("FAIL rand_w1_reg c%0d: got %b want %b", c, out_r1, g1);
         end
         compared++;
         if (out_r32 !== g32) begin
            mismatched++;
            $display("FAIL rand_w32_reg c%0d: got %h want %h", c, out_r32, g32);
         end
      end
   endtask

   initial begin
      rst_n = 1'b1;
      en    = 1'b0;
      sel8  = 4'h0;
      load_ramp();
      test_reset();
      test_sweep();
      test_isolation();
      test_enable_hold();
      test_reset_release();
      test_cache_block();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
